// File: rtl/zigbee_bit_serializer.sv
// zigbee_bit_serializer
// Turns data-rate edges into bit strobes and shifts out an alternating
// preamble followed by FIFO-fed payload bytes (LSB first) on tx_bit.
module zigbee_bit_serializer #(
    parameter int unsigned PREAMBLE_BITS = 32,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_rate,
    input  logic       start,
    input  logic [7:0] length,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx_bit,
    output logic       tx_active,
    output logic       done,
    output logic       underrun
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_DONE
    } state_t;

    state_t             state;
    logic               dr_q;
    logic               strobe;
    logic [7:0]         bit_cnt;
    logic [7:0]         byte_cnt;
    logic [7:0]         shreg;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [CNT_W-1:0]   fifo_cnt_nxt;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               byte_boundary;
    logic [7:0]         head;

    assign strobe        = data_rate ^ dr_q;
    assign fifo_empty    = (fifo_cnt == '0);
    assign head          = fifo_mem[rd_ptr];
    assign push          = byte_valid && byte_ready;
    assign byte_boundary = (bit_cnt == 8'd0);
    // The FIFO only pops on a payload byte boundary that is not an underrun.
    assign pop           = strobe && (state == S_PAYLOAD) && byte_boundary && !fifo_empty;

    // Edge detector register for the data-rate square wave.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dr_q <= 1'b0;
        end else begin
            dr_q <= data_rate;
        end
    end

    // Next FIFO occupancy; push and pop together cancel.
    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        if (push && !pop) begin
            fifo_cnt_nxt = fifo_cnt + CNT_W'(1);
        end else if (pop && !push) begin
            fifo_cnt_nxt = fifo_cnt - CNT_W'(1);
        end
    end

    // FIFO pointers, occupancy and registered ready flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            byte_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt   <= fifo_cnt_nxt;
            byte_ready <= (fifo_cnt_nxt < CNT_W'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= byte_in;
        end
    end

    // Frame sequencer: preamble, payload bytes, closing idle bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 8'd0;
            byte_cnt  <= 8'd0;
            shreg     <= 8'd0;
            tx_bit    <= 1'b0;
            tx_active <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_bit    <= 1'b0;
                    tx_active <= 1'b0;
                    if (start) begin
                        byte_cnt  <= length;
                        bit_cnt   <= 8'd0;
                        tx_active <= 1'b1;
                        state     <= S_PREAMBLE;
                    end
                end
                S_PREAMBLE: begin
                    if (strobe) begin
                        tx_bit <= ~bit_cnt[0];
                        if (bit_cnt == 8'(PREAMBLE_BITS - 1)) begin
                            bit_cnt <= 8'd0;
                            state   <= (byte_cnt == 8'd0) ? S_DONE : S_PAYLOAD;
                        end else begin
                            bit_cnt <= bit_cnt + 8'd1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (strobe) begin
                        if (byte_boundary && fifo_empty) begin
                            tx_bit    <= 1'b0;
                            tx_active <= 1'b0;
                            underrun  <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            if (byte_boundary) begin
                                tx_bit <= head[0];
                                shreg  <= {1'b0, head[7:1]};
                            end else begin
                                tx_bit <= shreg[0];
                                shreg  <= {1'b0, shreg[7:1]};
                            end
                            if (bit_cnt == 8'd7) begin
                                bit_cnt  <= 8'd0;
                                byte_cnt <= byte_cnt - 8'd1;
                                if (byte_cnt == 8'd1) begin
                                    state <= S_DONE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 8'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (strobe) begin
                        tx_bit    <= 1'b0;
                        tx_active <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zigbee_bit_serializer.sv
// Bench for zigbee_bit_serializer: expected bits come from a queue model of
// the payload FIFO and the frame layout (preamble, LSB-first bytes, idle bit).
`timescale 1ns/1ps
module tb_zigbee_bit_serializer;

    localparam int PB = 4;
    localparam int FD = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       data_rate;
    logic       start;
    logic [7:0] length;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       tx_bit;
    logic       tx_active;
    logic       done;
    logic       underrun;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] q[$];
    bit         hold_valid = 1'b0;

    zigbee_bit_serializer #(
        .PREAMBLE_BITS(PB),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .data_rate (data_rate),
        .start     (start),
        .length    (length),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .tx_bit    (tx_bit),
        .tx_active (tx_active),
        .done      (done),
        .underrun  (underrun)
    );

    always #5 clock = ~clock;

    // One clock edge; the model FIFO follows the push/pop rules.
    task automatic step(input bit pop_now);
        bit         pre_ready;
        bit         v;
        logic [7:0] b;
        pre_ready = (q.size() < FD);
        v = byte_valid;
        b = byte_in;
        @(posedge clock);
        #1;
        if (pop_now && q.size() != 0) void'(q.pop_front());
        if (v && pre_ready) q.push_back(b);
        if (hold_valid) byte_in = 8'($urandom);
        tests++;
        if (byte_ready !== (q.size() < FD)) begin
            fails++;
            $display("FAIL byte_ready: got %b expected %b (model count %0d)",
                     byte_ready, (q.size() < FD), q.size());
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        step(1'b0);
        byte_valid = 1'b0;
    endtask

    // Runs one frame with a strobe every n clocks and checks every cycle.
    task automatic do_frame(input int len, input int n, input bit poke_start);
        int         total;
        int         j;
        logic       exp_bit;
        logic       last;
        logic [7:0] cur;
        bit         pop_now;
        bit         exp_done;
        bit         exp_ur;
        total  = PB + 8 * len + 1;
        start  = 1'b1;
        length = 8'(len);
        step(1'b0);
        start  = 1'b0;
        tests++;
        if (tx_active !== 1'b1 || tx_bit !== 1'b0) begin
            fails++;
            $display("FAIL start_active: tx_active=%b tx_bit=%b expected 1/0", tx_active, tx_bit);
        end
        last = 1'b0;
        cur  = 8'd0;
        for (int k = 0; k < total; k++) begin
            for (int w = 0; w < n - 1; w++) begin
                if (poke_start && k == 1 && w == 0) begin
                    start  = 1'b1;
                    length = 8'(len + 1);
                end
                step(1'b0);
                start = 1'b0;
                tests++;
                if (tx_bit !== last || tx_active !== 1'b1 || done !== 1'b0 || underrun !== 1'b0) begin
                    fails++;
                    $display("FAIL hold k=%0d: tx_bit=%b active=%b done=%b ur=%b expected %b/1/0/0",
                             k, tx_bit, tx_active, done, underrun, last);
                end
            end
            pop_now  = 1'b0;
            exp_done = 1'b0;
            exp_ur   = 1'b0;
            exp_bit  = 1'b0;
            if (k < PB) begin
                exp_bit = (k % 2 == 0);
            end else if (k < PB + 8 * len) begin
                j = (k - PB) % 8;
                if (j == 0) begin
                    if (q.size() == 0) begin
                        exp_ur = 1'b1;
                    end else begin
                        cur     = q[0];
                        pop_now = 1'b1;
                    end
                end
                if (!exp_ur) exp_bit = cur[j];
            end else begin
                exp_done = 1'b1;
            end
            data_rate = ~data_rate;
            step(pop_now);
            tests++;
            if (tx_bit !== exp_bit || done !== exp_done || underrun !== exp_ur ||
                tx_active !== !(exp_done || exp_ur)) begin
                fails++;
                $display("FAIL strobe k=%0d: tx_bit=%b done=%b ur=%b active=%b expected %b/%b/%b/%b",
                         k, tx_bit, done, underrun, tx_active,
                         exp_bit, exp_done, exp_ur, !(exp_done || exp_ur));
            end
            last = exp_bit;
            if (exp_done || exp_ur) break;
        end
        step(1'b0);
        tests++;
        if (done !== 1'b0 || underrun !== 1'b0 || tx_active !== 1'b0 || tx_bit !== 1'b0) begin
            fails++;
            $display("FAIL frame_end: done=%b ur=%b active=%b tx_bit=%b expected all 0",
                     done, underrun, tx_active, tx_bit);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        data_rate  = 1'b0;
        start      = 1'b0;
        length     = 8'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if (tx_bit !== 1'b0 || tx_active !== 1'b0 || done !== 1'b0 ||
            underrun !== 1'b0 || byte_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_values: tx_bit=%b active=%b done=%b ur=%b ready=%b expected 0/0/0/0/1",
                     tx_bit, tx_active, done, underrun, byte_ready);
        end
        reset = 1'b1;
        repeat (2) step(1'b0);
    endtask

    task automatic test_basic();
        push_byte(8'hA5);
        push_byte(8'h3C);
        do_frame(2, 11, 1'b0);
    endtask

    task automatic test_len0();
        push_byte(8'h96);
        do_frame(0, 5, 1'b0);
        do_frame(1, 3, 1'b0);
    endtask

    task automatic test_underrun();
        push_byte(8'h5E);
        push_byte(8'hC1);
        do_frame(3, 4, 1'b0);
    endtask

    task automatic test_start_ignored();
        push_byte(8'h1F);
        do_frame(1, 4, 1'b1);
    endtask

    task automatic test_fifo_full();
        hold_valid = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'($urandom);
        repeat (6) step(1'b0);
        tests++;
        if (byte_ready !== 1'b0) begin
            fails++;
            $display("FAIL fifo_full: byte_ready=%b expected 0", byte_ready);
        end
        do_frame(1, 3, 1'b0);
        tests++;
        if (byte_ready !== 1'b0) begin
            fails++;
            $display("FAIL fifo_refill: byte_ready=%b expected 0", byte_ready);
        end
        hold_valid = 1'b0;
        byte_valid = 1'b0;
        do_frame(4, 2, 1'b0);
    endtask

    task automatic test_random();
        int npush;
        int len;
        for (int it = 0; it < 10; it++) begin
            npush = $urandom_range(0, FD - q.size());
            for (int p = 0; p < npush; p++) push_byte(8'($urandom));
            if ($urandom_range(0, 3) == 0) len = q.size() + 1;
            else len = $urandom_range(0, q.size());
            do_frame(len, $urandom_range(2, 9), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        push_byte(8'hE7);
        push_byte(8'h42);
        start  = 1'b1;
        length = 8'd2;
        step(1'b0);
        start  = 1'b0;
        for (int k = 0; k < PB + 3; k++) begin
            repeat (2) step(1'b0);
            data_rate = ~data_rate;
            step(k == PB);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (tx_bit !== 1'b0 || tx_active !== 1'b0 || byte_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_async: tx_bit=%b active=%b ready=%b expected 0/0/1",
                     tx_bit, tx_active, byte_ready);
        end
        q.delete();
        @(posedge clock);
        #1;
        tests++;
        if (tx_bit !== 1'b0 || tx_active !== 1'b0 || done !== 1'b0 ||
            underrun !== 1'b0 || byte_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: tx_bit=%b active=%b done=%b ur=%b ready=%b expected 0/0/0/0/1",
                     tx_bit, tx_active, done, underrun, byte_ready);
        end
        reset = 1'b1;
        repeat (3) step(1'b0);
        do_frame(1, 4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_underrun();
        test_start_ignored();
        test_fifo_full();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
